xbus_master_bridge: RTL and testbench



---
 rtl/xbus_master_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_xbus_master_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_master_bridge.sv
// Initiator end of the xbus link: serializes a 128-bit bus request into 24-bit words and collects the response.
// Optional response timeout is built when XBM_TIMEOUT_EN is defined.
module xbus_master_bridge #(
  parameter int TIMEOUT = 4095,
  parameter int LANES   = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cyc_i,
  input  logic         stb_i,
  input  logic         we_i,
  input  logic [15:0]  sel_i,
  input  logic [31:0]  adr_i,
  input  logic [127:0] dat_i,
  output logic         ack_o,
  output logic         err_o,
  output logic [127:0] dat_o,
  output logic [23:0]  xb_dat_o,
  input  logic [23:0]  xb_dat_i
);

  typedef enum logic [2:0] {
    IDLE,
    SADRL,
    SADRH,
    SDAT,
    SCTRL,
    WAIT_RESP,
    ACKED
  } state_e;

  state_e       state_q, state_d;
  logic         we_q, we_d;
  logic [15:0]  sel_q, sel_d;
  logic [31:0]  adr_q, adr_d;
  logic [127:0] datW_q, datW_d;
  logic [2:0]   lane_q, lane_d;
  logic [127:0] rxData_q, rxData_d;
  logic [127:0] datO_q, datO_d;
  logic         ack_q, ack_d;
  logic [23:0]  xbDat_q, xbDat_d;

`ifdef XBM_TIMEOUT_EN
  logic [15:0]  count_q, count_d;
  logic         err_q, err_d;
`endif

  logic [LANES-1:0] laneAct;
  logic [2:0]       firstLane;
  logic [2:0]       nextLane;
  logic             hasNext;
  logic             reqActive;
  logic             rxDone;
  logic             unusedRx;

  assign reqActive = cyc_i & stb_i;
  assign rxDone    = (xb_dat_i[23:20] == 4'h3) && (xb_dat_i[18:17] == 2'b11);
  assign unusedRx  = ^{xb_dat_i[19], xb_dat_i[16]};

  function automatic logic [23:0] dataWord(input logic [2:0] k, input logic [127:0] d);
    return {1'b1, k, 4'h0, d[{k, 4'b0000} +: 16]};
  endfunction

  // Lowest active lane overall and lowest active lane above the one just sent.
  always_comb begin
    laneAct   = '0;
    firstLane = '0;
    nextLane  = '0;
    hasNext   = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      laneAct[i] = |sel_q[2*i +: 2];
      if (laneAct[i]) firstLane = 3'(i);
      if (laneAct[i] && (i > int'(lane_q))) begin
        nextLane = 3'(i);
        hasNext  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    datW_d   = datW_q;
    lane_d   = lane_q;
    rxData_d = rxData_q;
    datO_d   = datO_q;
    ack_d    = 1'b0;
    xbDat_d  = 24'h0;
`ifdef XBM_TIMEOUT_EN
    count_d  = count_q;
    err_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (reqActive) begin
          we_d    = we_i;
          sel_d   = sel_i;
          adr_d   = adr_i;
          if (we_i) datW_d = dat_i;
          xbDat_d = {4'h1, adr_i[19:0]};
          state_d = SADRL;
        end
      end
      SADRL: begin
        if (!cyc_i) begin
          state_d = IDLE;
        end else begin
          xbDat_d = {4'h2, 8'h00, adr_q[31:20]};
          state_d = SADRH;
        end
      end
      SADRH: begin
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (we_q && (|sel_q)) begin
          lane_d  = firstLane;
          xbDat_d = dataWord(firstLane, datW_q);
          state_d = SDAT;
        end else begin
          xbDat_d = {4'h3, we_q, 1'b1, 2'b00, sel_q};
          state_d = SCTRL;
        end
      end
      SDAT: begin
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (hasNext) begin
          lane_d  = nextLane;
          xbDat_d = dataWord(nextLane, datW_q);
        end else begin
          xbDat_d = {4'h3, we_q, 1'b1, 2'b00, sel_q};
          state_d = SCTRL;
        end
      end
      SCTRL: begin
        rxData_d = '0;
`ifdef XBM_TIMEOUT_EN
        count_d  = '0;
`endif
        state_d  = WAIT_RESP;
      end
      WAIT_RESP: begin
`ifdef XBM_TIMEOUT_EN
        count_d = count_q + 16'd1;
`endif
        if (xb_dat_i[23]) begin
          rxData_d[{xb_dat_i[22:20], 4'b0000} +: 16] = xb_dat_i[15:0];
        end
        // A withdrawn request still consumes the response, but completes silently.
        if (rxDone) begin
          if (reqActive) begin
            ack_d   = 1'b1;
            if (!we_q) datO_d = rxData_q;
            state_d = ACKED;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef XBM_TIMEOUT_EN
        else if (count_d == 16'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ACKED;
        end
`endif
      end
      ACKED: begin
        if (!reqActive) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      datW_q   <= '0;
      lane_q   <= '0;
      rxData_q <= '0;
      datO_q   <= '0;
      ack_q    <= 1'b0;
      xbDat_q  <= '0;
`ifdef XBM_TIMEOUT_EN
      count_q  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      datW_q   <= datW_d;
      lane_q   <= lane_d;
      rxData_q <= rxData_d;
      datO_q   <= datO_d;
      ack_q    <= ack_d;
      xbDat_q  <= xbDat_d;
`ifdef XBM_TIMEOUT_EN
      count_q  <= count_d;
      err_q    <= err_d;
`endif
    end
  end

  assign ack_o    = ack_q;
  assign dat_o    = datO_q;
  assign xb_dat_o = xbDat_q;

`ifdef XBM_TIMEOUT_EN
  assign err_o = err_q;
`else
  localparam int unusedTimeout = TIMEOUT;
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_xbus_master_bridge.sv
// Scoreboard bench for xbus_master_bridge: the driver queues expected link words and acks,
// a negedge monitor pops and compares them whenever the DUT presents a word or an ack.
module tb_xbus_master_bridge;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cyc_i;
  logic         stb_i;
  logic         we_i;
  logic [15:0]  sel_i;
  logic [31:0]  adr_i;
  logic [127:0] dat_i;
  logic         ack_o;
  logic         err_o;
  logic [127:0] dat_o;
  logic [23:0]  xb_dat_o;
  logic [23:0]  xb_dat_i;

  xbus_master_bridge #(.TIMEOUT(16), .LANES(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cyc_i    (cyc_i),
    .stb_i    (stb_i),
    .we_i     (we_i),
    .sel_i    (sel_i),
    .adr_i    (adr_i),
    .dat_i    (dat_i),
    .ack_o    (ack_o),
    .err_o    (err_o),
    .dat_o    (dat_o),
    .xb_dat_o (xb_dat_o),
    .xb_dat_i (xb_dat_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [23:0]  expWords[$];
  logic [127:0] expAck[$];
  int ctrlSeen = 0;
  int ackSeen = 0;
  int errSeen = 0;
  int cycleNo = 0;
  int ctrlCycle = 0;
  int errCycle = 0;
  bit monEnable = 1'b0;
  bit errExpected = 1'b0;
  logic [127:0] lastDatO = '0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flagUnexpected(input string name, input logic [127:0] act);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=%h required=nothing", name, act);
  endtask

  // Monitor: every non-NOP word and every ack is matched against the scoreboard.
  always @(negedge clk_i) begin
    cycleNo++;
    if (!rst_i && monEnable) begin
      if (xb_dat_o != 24'h0) begin
        if (xb_dat_o[23:20] == 4'h3) begin
          ctrlSeen++;
          ctrlCycle = cycleNo;
        end
        if (expWords.size() == 0) flagUnexpected("unexpected_word", 128'(xb_dat_o));
        else checkOutput("xb_word", 128'(xb_dat_o), 128'(expWords.pop_front()));
      end
      if (ack_o) begin
        ackSeen++;
        if (expAck.size() == 0) flagUnexpected("unexpected_ack", dat_o);
        else checkOutput("ack_dat", dat_o, expAck.pop_front());
      end
      if (err_o) begin
        errSeen++;
        errCycle = cycleNo;
        if (!errExpected) flagUnexpected("unexpected_err", 128'(err_o));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [23:0] randWord(input bit allowDone);
    logic [23:0] w;
    logic [19:0] p;
    p = 20'($urandom);
    case ($urandom_range(0, 5))
      0: w = 24'h0;
      1: w = {4'h1, p};
      2: w = {4'h2, p};
      3: begin
        if (allowDone && ($urandom_range(0, 1) == 1)) w = 24'h360000;
        else begin
          p[17] = 1'b0;
          w = {4'h3, p};
        end
      end
      default: w = {1'b1, 3'($urandom_range(0, 7)), 4'h0, p[15:0]};
    endcase
    return w;
  endfunction

  // Expected link words follow straight from the request: address low, address high,
  // one word per active sel pair (writes only) in lane order, then CTRL.
  task automatic pushRequestWords(input bit we, input logic [15:0] sel, input logic [31:0] adr,
                                  input logic [127:0] dat);
    expWords.push_back({4'h1, adr[19:0]});
    expWords.push_back({4'h2, 8'h00, adr[31:20]});
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        if (sel[2*k +: 2] != 2'b00) expWords.push_back({4'(8 + k), 4'h0, dat[16*k +: 16]});
      end
    end
    expWords.push_back({4'h3, we, 1'b1, 2'b00, sel});
  endtask

  task automatic waitCtrl(input int base, output bit ok);
    int c;
    c = 0;
    while (ctrlSeen == base && c < 60) begin
      tick();
      c++;
    end
    ok = (ctrlSeen != base);
    if (!ok) flagUnexpected("ctrl_timeout", 128'(c));
  endtask

  task automatic applyStimulus(input bit we, input logic [15:0] sel, input logic [31:0] adr,
                               input logic [127:0] dat, input logic [23:0] resp [8],
                               input int nResp, input bit withdraw, input int hold);
    logic [127:0] rx;
    bit ok;
    int base;
    int c;
    rx = '0;
    pushRequestWords(we, sel, adr, dat);
    base = ctrlSeen;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i = we;
    sel_i = sel;
    adr_i = adr;
    dat_i = dat;
    xb_dat_i = randWord(1'b1);
    tick();
    we_i = 1'($urandom);
    sel_i = 16'($urandom);
    adr_i = $urandom;
    dat_i = {$urandom, $urandom, $urandom, $urandom};
    waitCtrl(base, ok);
    if (!ok) begin
      cyc_i = 1'b0;
      stb_i = 1'b0;
      expWords.delete();
      repeat (4) tick();
      return;
    end
    if (withdraw) begin
      cyc_i = 1'b0;
      stb_i = 1'b0;
    end
    for (int n = 0; n < nResp; n++) begin
      xb_dat_i = resp[n];
      if (resp[n][23]) rx[16*resp[n][22:20] +: 16] = resp[n][15:0];
      tick();
    end
    if (!withdraw) begin
      expAck.push_back(we ? lastDatO : rx);
      if (!we) lastDatO = rx;
    end
    base = ackSeen;
    xb_dat_i = 24'h360000;
    tick();
    xb_dat_i = 24'h0;
    if (!withdraw) begin
      c = 0;
      while (ackSeen == base && c < 8) begin
        tick();
        c++;
      end
      if (ackSeen == base) flagUnexpected("ack_timeout", 128'(c));
      repeat (hold) tick();
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    repeat (2) tick();
  endtask

  logic [23:0]  resp [8];
  logic [127:0] dat;
  logic [15:0]  sel;
  int base;
  bit ok;

  initial begin
    rst_i = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i = 1'b0;
    sel_i = '0;
    adr_i = '0;
    dat_i = '0;
    xb_dat_i = '0;
    for (int i = 0; i < 8; i++) resp[i] = '0;
    repeat (3) tick();
    checkOutput("reset_xb", 128'(xb_dat_o), 128'h0);
    checkOutput("reset_ack", 128'(ack_o), 128'h0);
    checkOutput("reset_err", 128'(err_o), 128'h0);
    checkOutput("reset_dat", dat_o, 128'h0);
    rst_i = 1'b0;
    monEnable = 1'b1;
    tick();

    $display("[TB] full write");
    for (int k = 0; k < 8; k++) dat[16*k +: 16] = 16'(k);
    applyStimulus(1'b1, 16'hFFFF, 32'h1234_5678, dat, resp, 0, 1'b0, 0);

    $display("[TB] directed read");
    resp[0] = 24'hA0BEEF;
    resp[1] = 24'hB0CAFE;
    applyStimulus(1'b0, 16'h00F0, 32'hDEAD_0010, '0, resp, 2, 1'b0, 0);
    checkOutput("read_dat_o", dat_o, {64'h0, 32'hCAFE_BEEF, 32'h0});

    $display("[TB] sparse write, held strobe");
    applyStimulus(1'b1, 16'h3003, 32'h0000_0100, {$urandom, $urandom, $urandom, $urandom}, resp, 0, 1'b0, 5);

    $display("[TB] withdraw during data phase");
    sel = 16'($urandom) | 16'h0003 | 16'h0C00;
    dat = {$urandom, $urandom, $urandom, $urandom};
    expWords.push_back({4'h1, 20'h4_5678});
    expWords.push_back({4'h2, 8'h00, 12'hABC});
    expWords.push_back({4'h8, 4'h0, dat[15:0]});
    base = ackSeen;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i = 1'b1;
    sel_i = sel;
    adr_i = 32'hABC4_5678;
    dat_i = dat;
    repeat (3) tick();
    cyc_i = 1'b0;
    repeat (3) tick();
    stb_i = 1'b0;
    xb_dat_i = 24'h360000;
    tick();
    xb_dat_i = 24'h0;
    repeat (3) tick();
    checkOutput("abort_words_left", 128'(expWords.size()), 128'h0);
    checkOutput("abort_no_ack", 128'(ackSeen - base), 128'h0);

    $display("[TB] reset during WAIT_RESP");
    pushRequestWords(1'b0, 16'h0F0F, 32'h5555_AAAA, '0);
    base = ctrlSeen;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i = 1'b0;
    sel_i = 16'h0F0F;
    adr_i = 32'h5555_AAAA;
    waitCtrl(base, ok);
    xb_dat_i = 24'h81234;
    tick();
    rst_i = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    xb_dat_i = 24'h360000;
    tick();
    checkOutput("rst_mid_xb", 128'(xb_dat_o), 128'h0);
    checkOutput("rst_mid_ack", 128'(ack_o), 128'h0);
    checkOutput("rst_mid_dat", dat_o, 128'h0);
    rst_i = 1'b0;
    lastDatO = '0;
    tick();
    xb_dat_i = 24'h0;
    repeat (3) tick();

`ifdef XBM_TIMEOUT_EN
    $display("[TB] response timeout");
    pushRequestWords(1'b0, 16'h0001, 32'h0000_0040, '0);
    base = ctrlSeen;
    errExpected = 1'b1;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i = 1'b0;
    sel_i = 16'h0001;
    adr_i = 32'h0000_0040;
    waitCtrl(base, ok);
    base = errSeen;
    for (int c = 0; c < 40 && errSeen == base; c++) tick();
    checkOutput("err_seen", 128'(errSeen - base), 128'h1);
    checkOutput("err_latency", 128'(errCycle - ctrlCycle), 128'd17);
    repeat (3) tick();
    cyc_i = 1'b0;
    stb_i = 1'b0;
    repeat (2) tick();
    errExpected = 1'b0;
`endif

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      int nr;
      bit we;
      we = 1'($urandom);
      sel = 16'($urandom);
      if ($urandom_range(0, 5) == 0) sel = '0;
      else if ($urandom_range(0, 3) == 0) sel = sel & 16'hC003;
      nr = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) resp[i] = randWord(1'b0);
      applyStimulus(we, sel, $urandom, {$urandom, $urandom, $urandom, $urandom}, resp, nr,
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 5));
    end

    repeat (4) tick();
    checkOutput("words_left", 128'(expWords.size()), 128'h0);
    checkOutput("acks_left", 128'(expAck.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
